// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter: line-atomic round-robin sharing of one UART transmitter; `define UART_TX_ARB_CRLF_EN appends LF after each CR
module uart_tx_line_arbiter #(
  parameter int N_REQ = 2,
  parameter logic [7:0] EOL_CHAR = 8'h0D,
  parameter int TIMEOUT = 4096,
  localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_REQ-1:0]   req_din,
  input  logic [N_REQ-1:0]     req_empty,
  output logic [N_REQ-1:0]     req_re,
  output logic [7:0]           out_din,
  output logic                 out_empty,
  input  logic                 out_re,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {
    IDLE,
    LOCKED
`ifdef UART_TX_ARB_CRLF_EN
    , INSERT_LF
`endif
  } state_t;
  state_t state;
  logic [GW-1:0] last, pick;
  logic [CW-1:0] cnt;
  logic found, locked, lf, sel_empty, accept;
  logic [7:0] sel_din;
  assign locked = state == LOCKED;
`ifdef UART_TX_ARB_CRLF_EN
  assign lf = state == INSERT_LF;
`else
  assign lf = 1'b0;
`endif
  // round-robin scan starting just after the last released requester
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && !req_empty[(int'(last) + k) % N_REQ]) begin
        found = 1'b1;
        pick = GW'((int'(last) + k) % N_REQ);
      end
    end
  end
  // pass the granted FIFO through while locked, inject LF after CR when enabled
  always_comb begin
    sel_empty = req_empty[grant_id];
    sel_din = req_din[int'(grant_id)*8 +: 8];
    accept = locked & out_re & ~sel_empty;
    out_empty = locked ? sel_empty : ~lf;
    out_din = locked ? sel_din : lf ? 8'h0A : 8'h00;
    req_re = accept ? (N_REQ'(1) << grant_id) : '0;
    busy = state != IDLE;
  end
  // grant, hold until end-of-line or idle timeout, then release through IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      last <= GW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            grant_id <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            cnt <= '0;
            if (sel_din == EOL_CHAR) begin
              last <= grant_id;
`ifdef UART_TX_ARB_CRLF_EN
              state <= INSERT_LF;
`else
              state <= IDLE;
`endif
            end
          end else if (sel_empty) begin
            if (TIMEOUT > 0 && cnt == TLIM) begin
              last <= grant_id;
              state <= IDLE;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_ARB_CRLF_EN
        INSERT_LF: if (out_re) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// tb_uart_tx_line_arbiter: scoreboard bench for the line-atomic UART transmitter arbiter
module tb_uart_tx_line_arbiter;
`ifdef UART_TX_ARB_CRLF_EN
  localparam int LF = 1;
`else
  localparam int LF = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [15:0] req_din;
  logic [1:0] req_empty, req_re;
  logic [7:0] out_din;
  logic out_empty, out_re, busy;
  logic [0:0] grant_id;
  logic [7:0] q0[$], q1[$], exp_q[$];
  int acc_cyc[$];
  logic acc_gid[$];
  int checks = 0, errors = 0, cyc = 0, rx = 0, re_cnt0 = 0, re_cnt1 = 0;
  logic [1:0] s_re;
  logic s_busy, s_oe, s_gid, s_acc;
  logic [7:0] s_od;

  uart_tx_line_arbiter #(.N_REQ(2), .EOL_CHAR(8'h0D), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_din(req_din), .req_empty(req_empty), .req_re(req_re),
    .out_din(out_din), .out_empty(out_empty), .out_re(out_re), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    req_empty = {q1.size() == 0, q0.size() == 0};
    req_din = {q1.size() != 0 ? q1[0] : 8'h00, q0.size() != 0 ? q0[0] : 8'h00};
  endtask

  task automatic push_line(input int who, input string s, input bit eol);
    logic [7:0] b;
    for (int i = 0; i < s.len() + int'(eol); i++) begin
      b = (i < s.len()) ? s[i] : 8'h0D;
      if (who == 0) q0.push_back(b);
      else q1.push_back(b);
      exp_q.push_back(b);
      if (b == 8'h0D && LF == 1) exp_q.push_back(8'h0A);
    end
    refresh();
  endtask

  // one clock: sample at the falling edge, act as FIFOs and transmitter after the rising edge
  task automatic cycle();
    logic [7:0] e;
    #4;
    s_re = req_re;
    s_busy = busy;
    s_oe = out_empty;
    s_od = out_din;
    s_gid = grant_id;
    s_acc = out_re && !out_empty;
    if (s_acc) begin
      rx++;
      acc_cyc.push_back(cyc);
      acc_gid.push_back(grant_id);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_byte got %h expected nothing", out_din);
      end else begin
        e = exp_q.pop_front();
        if (out_din !== e) begin
          errors++;
          $display("FAIL rx_byte got %h expected %h", out_din, e);
        end
      end
    end
    re_cnt0 += int'(s_re[0]);
    re_cnt1 += int'(s_re[1]);
    @(posedge clk);
    #1;
    if (s_re[0] && q0.size() != 0) void'(q0.pop_front());
    if (s_re[1] && q1.size() != 0) void'(q1.pop_front());
    refresh();
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_re = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    refresh();
    cycle();
    rst = 1'b0;
    rx = 0;
    re_cnt0 = 0;
    re_cnt1 = 0;
    acc_cyc.delete();
    acc_gid.delete();
  endtask

  task automatic run_rx(input int n);
    for (int i = 0; i < 200 && rx < n; i++) cycle();
    checks++;
    if (rx < n) begin
      errors++;
      $display("FAIL rx_timeout got %0d bytes expected %0d", rx, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    checks += 5;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", s_busy); end
    if (s_oe !== 1'b1) begin errors++; $display("FAIL reset_out_empty got %b expected 1", s_oe); end
    if (s_re !== 2'b00) begin errors++; $display("FAIL reset_req_re got %b expected 00", s_re); end
    if (s_gid !== 1'b0) begin errors++; $display("FAIL reset_grant_id got %b expected 0", s_gid); end
    if (s_od !== 8'h00) begin errors++; $display("FAIL reset_out_din got %h expected 00", s_od); end
  endtask

  task automatic test_single_line();
    do_reset();
    push_line(0, "6 2 +", 1'b1);
    out_re = 1'b1;
    run_rx(6 + LF);
    checks += 4;
    if (re_cnt0 != 6) begin errors++; $display("FAIL single_re_count got %0d expected 6", re_cnt0); end
    if (s_busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_eol got %b expected 1", s_busy); end
    if (s_gid !== 1'b0) begin errors++; $display("FAIL single_grant_id got %b expected 0", s_gid); end
    cycle();
    if (s_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_eol got %b expected 0", s_busy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_two_lines();
    do_reset();
    push_line(0, "AB", 1'b1);
    push_line(1, "xy", 1'b1);
    out_re = 1'b1;
    run_rx(6 + 2 * LF);
    checks += 4;
    if (acc_gid[0] !== 1'b0) begin errors++; $display("FAIL two_first_gid got %b expected 0", acc_gid[0]); end
    if (acc_gid[3 + LF] !== 1'b1) begin errors++; $display("FAIL two_second_gid got %b expected 1", acc_gid[3 + LF]); end
    if (acc_cyc[3 + LF] - acc_cyc[2 + LF] != 2) begin
      errors++;
      $display("FAIL two_gap got %0d expected 2", acc_cyc[3 + LF] - acc_cyc[2 + LF]);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL two_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    push_line(0, "pq", 1'b1);
    out_re = 1'b1;
    cycle();
    cycle();
    push_line(1, "z", 1'b1);
    run_rx(3 + LF);
    push_line(0, "C", 1'b1);
    run_rx(7 + 3 * LF);
    checks += 3;
    if (acc_gid[3 + LF] !== 1'b1) begin errors++; $display("FAIL rr_r1_gid got %b expected 1", acc_gid[3 + LF]); end
    if (acc_gid[5 + 2 * LF] !== 1'b0) begin errors++; $display("FAIL rr_r0_gid got %b expected 0", acc_gid[5 + 2 * LF]); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n, bad;
    do_reset();
    push_line(0, "ab", 1'b0);
    push_line(1, "k", 1'b1);
    out_re = 1'b1;
    run_rx(2);
    n = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!s_busy) break;
      n++;
      if (s_re != 2'b00) bad++;
    end
    checks += 2;
    if (n != 16) begin errors++; $display("FAIL timeout_busy_cycles got %0d expected 16", n); end
    if (bad != 0) begin errors++; $display("FAIL timeout_req_re got %0d strobes expected 0", bad); end
    run_rx(4 + LF);
    checks += 3;
    if (acc_gid[2] !== 1'b1) begin errors++; $display("FAIL timeout_next_gid got %b expected 1", acc_gid[2]); end
    if (acc_cyc[2] - acc_cyc[1] != 18) begin
      errors++;
      $display("FAIL timeout_release_gap got %0d expected 18", acc_cyc[2] - acc_cyc[1]);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midline();
    int rcyc;
    do_reset();
    push_line(0, "abcd", 1'b1);
    out_re = 1'b1;
    run_rx(2);
    rst = 1'b1;
    out_re = 1'b0;
    cycle();
    rst = 1'b0;
    out_re = 1'b1;
    rcyc = cyc;
    cycle();
    checks += 3;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", s_busy); end
    if (s_oe !== 1'b1) begin errors++; $display("FAIL midrst_out_empty got %b expected 1", s_oe); end
    if (s_re !== 2'b00) begin errors++; $display("FAIL midrst_req_re got %b expected 00", s_re); end
    run_rx(5 + LF);
    checks += 3;
    if (acc_cyc[2] != rcyc + 1) begin errors++; $display("FAIL midrst_resume_cycle got %0d expected %0d", acc_cyc[2], rcyc + 1); end
    if (acc_gid[2] !== 1'b0) begin errors++; $display("FAIL midrst_gid got %b expected 0", acc_gid[2]); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_line_end();
    do_reset();
    push_line(0, "7", 1'b1);
    out_re = 1'b1;
    run_rx(2 + LF);
    checks += 3;
    if (re_cnt0 != 2) begin errors++; $display("FAIL eol_re_count got %0d expected 2", re_cnt0); end
    if (s_busy !== 1'b1) begin errors++; $display("FAIL eol_busy_at_last got %b expected 1", s_busy); end
    cycle();
    if (s_busy !== 1'b0) begin errors++; $display("FAIL eol_busy_after got %b expected 0", s_busy); end
  endtask

  initial begin
    rst = 1'b1;
    out_re = 1'b0;
    refresh();
    @(posedge clk);
    #1;
    test_reset();
    test_single_line();
    test_two_lines();
    test_round_robin();
    test_timeout();
    test_reset_midline();
    test_line_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
